wrapped_phase_3steps: RTL

Computes the wrapped phase of one fringe frequency from three 8-bit phase-shifted intensity samples (shifts −2π/3, 0, +2π/3) using a fully pipelined CORDIC vectoring engine. Output is a fixed-point phase in [0, 2π). Three instances, one per fringe frequency, feed the `phase1_i`/`phase2_i`/`phase3_i` inputs of the downstream 3-step heterodyne absolute-phase stage.

---
 rtl/pmp_pkg.sv | 26 ++
 rtl/cordic_vec_stage.sv | 73 +++++++
 rtl/wrapped_phase_3steps.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pmp_pkg.sv
// Shared constants and the CORDIC pipeline stage record for the wrapped-phase
// computation. All angles are fixed point: Z in Q16 radians, phase in Q13.
package pmp_pkg;

    localparam int XY_W = 26;
    localparam int Z_W  = 20;

    localparam int PI_2_Q13  = 51471;
    localparam int PI_Q16    = 205887;
    localparam int SQRT3_Q12 = 7094;

    // round(atan(2^-k) * 65536)
    localparam int ATAN_Q16 [0:17] = '{
        51472, 30386, 16055, 8150, 4091, 2047, 1024, 512, 256,
        128,   64,    32,    16,   8,    4,    2,    1,   0
    };

    typedef struct packed {
        logic [XY_W-1:0] x;
        logic [XY_W-1:0] y;
        logic [Z_W-1:0]  z;
        logic            vld;
        logic            tlast;
    } stage_t;

endpackage

// File: rtl/cordic_vec_stage.sv
// One registered CORDIC vectoring micro-rotation with shift K.
// Data registers are not reset; only the valid/tlast bits are.
module cordic_vec_stage
    import pmp_pkg::*;
#(
    parameter int unsigned K = 0
) (
    input  logic   clk,
    input  logic   rst_n,
    input  stage_t i_stage,
    output stage_t o_stage
);

    localparam logic signed [Z_W-1:0] ATAN_K = Z_W'(ATAN_Q16[K]);

    logic signed [XY_W-1:0] w_x_in;
    logic signed [XY_W-1:0] w_y_in;
    logic signed [XY_W-1:0] w_x_sh;
    logic signed [XY_W-1:0] w_y_sh;
    logic signed [Z_W-1:0]  w_z_in;
    logic signed [XY_W-1:0] w_x_nx;
    logic signed [XY_W-1:0] w_y_nx;
    logic signed [Z_W-1:0]  w_z_nx;

    logic [XY_W-1:0] r_x;
    logic [XY_W-1:0] r_y;
    logic [Z_W-1:0]  r_z;
    logic            r_vld;
    logic            r_tlast;

    assign w_x_in = signed'(i_stage.x);
    assign w_y_in = signed'(i_stage.y);
    assign w_z_in = signed'(i_stage.z);
    assign w_x_sh = w_x_in >>> K;
    assign w_y_sh = w_y_in >>> K;

    // Rotate towards Y = 0; both shifts use the pre-update X and Y.
    always_comb begin
        w_x_nx = w_x_in;
        w_y_nx = w_y_in;
        w_z_nx = w_z_in;
        if (!w_y_in[XY_W-1]) begin
            w_x_nx = w_x_in + w_y_sh;
            w_y_nx = w_y_in - w_x_sh;
            w_z_nx = w_z_in + ATAN_K;
        end else begin
            w_x_nx = w_x_in - w_y_sh;
            w_y_nx = w_y_in + w_x_sh;
            w_z_nx = w_z_in - ATAN_K;
        end
    end

    // Control bits of the stage, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld   <= 1'b0;
            r_tlast <= 1'b0;
        end else begin
            r_vld   <= i_stage.vld;
            r_tlast <= i_stage.tlast;
        end
    end

    // Datapath registers of the stage.
    always_ff @(posedge clk) begin
        r_x <= w_x_nx;
        r_y <= w_y_nx;
        r_z <= w_z_nx;
    end

    assign o_stage = '{x: r_x, y: r_y, z: r_z, vld: r_vld, tlast: r_tlast};

endmodule

// File: rtl/wrapped_phase_3steps.sv
// Wrapped phase of one fringe frequency from three phase-shifted samples,
// via a fully pipelined CORDIC vectoring engine. Latency ITER+5 cycles.
// Optional low-modulation masking: define WRAPPED_PHASE_MOD_MASK_EN.
module wrapped_phase_3steps
    import pmp_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int ITER       = 16,
    parameter int MOD_THRESH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vld_i,
    input  logic [7:0]            i1_i,
    input  logic [7:0]            i2_i,
    input  logic [7:0]            i3_i,
    input  logic                  tlast_i,
    output logic                  vld_o,
    output logic [DATA_WIDTH-1:0] phase_o,
    output logic                  mask_o,
    output logic                  tlast_o
);

    localparam logic signed [XY_W-1:0] SQRT3_C = XY_W'(SQRT3_Q12);
    localparam logic signed [Z_W-1:0]  PI2_C   = Z_W'(PI_2_Q13);
    localparam logic signed [Z_W-1:0]  RND_C   = Z_W'(4);

    // S0..S3 control shift chain (bit n = stage Sn)
    logic [3:0] r_vld_sr;
    logic [3:0] r_tlast_sr;

    // S0 input registers
    logic [7:0] r_i1;
    logic [7:0] r_i2;
    logic [7:0] r_i3;
    // S1 differences
    logic [8:0]  r_d;
    logic [10:0] r_x1;
    // S2 scaled vector
    logic [XY_W-1:0] r_xs;
    logic [XY_W-1:0] r_ys;
    // S3 pre-rotated vector
    logic [XY_W-1:0] r_s3x;
    logic [XY_W-1:0] r_s3y;
    logic [Z_W-1:0]  r_s3z;

    logic signed [XY_W-1:0] w_d_ext;
    logic signed [XY_W-1:0] w_ys;
    logic [XY_W-1:0]        w_s3x;
    logic [XY_W-1:0]        w_s3y;
    logic [Z_W-1:0]         w_s3z;

    stage_t w_chain [0:ITER];
    stage_t w_last;

    logic signed [Z_W-1:0] w_zr;
    logic signed [Z_W-1:0] w_p0;
    logic signed [Z_W-1:0] w_p;
    logic                  w_zero;
    logic [15:0]           w_phase16;
    logic [15:0]           w_phase_sel;
    logic                  w_lowmod;
    logic                  w_unused;

    logic                  r_vld_o;
    logic                  r_tlast_o;
    logic                  r_mask_o;
    logic [DATA_WIDTH-1:0] r_phase_o;

    // Valid/tlast travel alongside the data; tlast is only kept with a valid sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_sr   <= '0;
            r_tlast_sr <= '0;
        end else begin
            r_vld_sr   <= {r_vld_sr[2:0], vld_i};
            r_tlast_sr <= {r_tlast_sr[2:0], tlast_i & vld_i};
        end
    end

    assign w_d_ext = {{(XY_W-9){r_d[8]}}, r_d};
    assign w_ys    = w_d_ext * SQRT3_C;

    // Fold the left half-plane onto the right by a pi rotation.
    always_comb begin
        w_s3x = r_xs;
        w_s3y = r_ys;
        w_s3z = '0;
        if (r_xs[XY_W-1]) begin
            w_s3x = -r_xs;
            w_s3y = -r_ys;
            w_s3z = Z_W'(PI_Q16);
        end
    end

    // Front-end datapath S0..S3; not reset.
    always_ff @(posedge clk) begin
        r_i1  <= i1_i;
        r_i2  <= i2_i;
        r_i3  <= i3_i;
        r_d   <= {1'b0, r_i1} - {1'b0, r_i3};
        r_x1  <= {2'b00, r_i2, 1'b0} - {3'b000, r_i1} - {3'b000, r_i3};
        r_xs  <= {{(XY_W-23){r_x1[10]}}, r_x1, 12'b0};
        r_ys  <= w_ys;
        r_s3x <= w_s3x;
        r_s3y <= w_s3y;
        r_s3z <= w_s3z;
    end

    assign w_chain[0] = '{x: r_s3x, y: r_s3y, z: r_s3z,
                          vld: r_vld_sr[3], tlast: r_tlast_sr[3]};

    for (genvar k = 0; k < ITER; k++) begin : g_cordic
        cordic_vec_stage #(
            .K(k)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_stage(w_chain[k]),
            .o_stage(w_chain[k+1])
        );
    end

    assign w_last = w_chain[ITER];

    // Q16 -> Q13 with rounding, then wrap into [0, 2pi).
    assign w_zr = signed'(w_last.z) + RND_C;
    assign w_p0 = w_zr >>> 3;

    always_comb begin
        w_p = w_p0;
        if (w_p0 < 0) begin
            w_p = w_p0 + PI2_C;
        end else if (w_p0 >= PI2_C) begin
            w_p = w_p0 - PI2_C;
        end
    end

    // X never shrinks in vectoring mode, so a final X of zero means the input
    // vector was zero; report phase 0 instead of the accumulated atan sum.
    assign w_zero    = (w_last.x == '0);
    assign w_phase16 = w_zero ? '0 : w_p[15:0];

`ifdef WRAPPED_PHASE_MOD_MASK_EN
    logic [13:0] w_mag;
    assign w_mag       = w_last.x[XY_W-1:12];
    assign w_lowmod    = (w_mag < 14'(MOD_THRESH));
    assign w_phase_sel = w_lowmod ? '0 : w_phase16;
`else
    logic [13:0] w_unused_thresh;
    assign w_unused_thresh = 14'(MOD_THRESH);
    assign w_lowmod        = 1'b0;
    assign w_phase_sel     = w_phase16;
`endif

    assign w_unused = ^{w_last.y, w_p[Z_W-1:16]};

    // Output register; phase/mask only update on a valid sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_o   <= 1'b0;
            r_tlast_o <= 1'b0;
            r_mask_o  <= 1'b0;
            r_phase_o <= '0;
        end else begin
            r_vld_o   <= w_last.vld;
            r_tlast_o <= w_last.tlast;
            if (w_last.vld) begin
                r_phase_o <= DATA_WIDTH'(w_phase_sel);
                r_mask_o  <= w_lowmod;
            end
        end
    end

    assign vld_o   = r_vld_o;
    assign tlast_o = r_tlast_o;
    assign mask_o  = r_mask_o;
    assign phase_o = r_phase_o;

endmodule
